// File: rtl/handshake_fifo_param.sv
// Valid/ready FIFO, DEPTH x DATA_W, first-word-fall-through; push-to-valid latency 1 cycle, no bypass.
// Backpressure: ready_pre_o drops only when full (never depends on ready_post_i); flush_i blocks both sides.
module handshake_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       valid_pre_i,
  output logic                       ready_pre_o,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       valid_post_o,
  input  logic                       ready_post_i,
  output logic [DATA_W-1:0]          data_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       almost_full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE     = 1;
  localparam logic [AW:0] AFULL_V = AFULL_TH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wp;
  logic [AW:0]       rp;
  logic [AW:0]       cnt;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // Wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

  assign ready_pre_o  = !full && !flush_i;
  assign valid_post_o = !empty && !flush_i;
  assign push         = valid_pre_i && ready_pre_o;
  assign pop          = valid_post_o && ready_post_i;

  assign data_o        = valid_post_o ? mem[rp[AW-1:0]] : '0;
  assign count_o       = cnt;
  assign almost_full_o = (cnt >= AFULL_V);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + ONE;
      if (pop)  rp <= rp + ONE;
      if (push && !pop)      cnt <= cnt + ONE;
      else if (pop && !push) cnt <= cnt - ONE;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= data_i;
  end

endmodule

// File: tb/tb_handshake_fifo_param.sv
// Bench for handshake_fifo_param: vector table, directed corner sequences, and random traffic vs a queue model.
module tb_handshake_fifo_param;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int AF = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid_pre_i = 1'b0;
  logic          ready_pre_o;
  logic [DW-1:0] data_i = '0;
  logic          valid_post_o;
  logic          ready_post_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          flush_i = 1'b0;
  logic [2:0]    count_o;
  logic          almost_full_o;

  handshake_fifo_param #(.DATA_W(DW), .DEPTH(D), .AFULL_TH(AF)) dut (
    .clk(clk), .reset_n(reset_n),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o), .data_i(data_i),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i), .data_o(data_o),
    .flush_i(flush_i), .count_o(count_o), .almost_full_o(almost_full_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic mon_en  = 1'b0;
  logic stab_en = 1'b0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_dat = '0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       f;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    int         e_cnt;
    logic       e_af;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: a bounded queue; flush empties it, pop from head, push to tail.
  function automatic void model_step(input logic v, input logic [7:0] d, input logic r, input logic f);
    logic rdy, vld;
    rdy = (q.size() < D) && !f;
    vld = (q.size() > 0) && !f;
    if (f) q.delete();
    else begin
      if (vld && r) void'(q.pop_front());
      if (v && rdy) q.push_back(d);
    end
  endfunction

  // Caller is at posedge+1; returns at next posedge+1.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
    logic erdy, evld;
    logic [7:0] edat;
    valid_pre_i = v; data_i = d; ready_post_i = r; flush_i = f;
    #3;
    erdy = (q.size() < D) && !f;
    evld = (q.size() > 0) && !f;
    edat = evld ? q[0] : 8'h00;
    chk("ready_pre", ready_pre_o, erdy);
    chk("valid_post", valid_post_o, evld);
    chk("data", data_o, edat);
    chk("count", count_o, q.size());
    chk("almost_full", almost_full_o, q.size() >= AF);
    @(posedge clk);
    model_step(v, d, r, f);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && valid_post_o && ready_post_i) got.push_back(data_o);
    if (stab_en) begin
      if (prev_hold && valid_post_o) chk("hold_stable", data_o, prev_dat);
      prev_hold = valid_post_o && !ready_post_i;
      prev_dat  = data_o;
    end
  end

  vec_t vt[12];

  initial begin
    // Fill to full, full+pop without push, refill, drain.
    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1, 1'b0};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2, 1'b0};
    vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3, 1'b1};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4, 1'b1};
    vt[5]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 4, 1'b1};
    vt[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 3, 1'b1};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 4, 1'b1};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 3, 1'b1};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 2, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};

    // Reset state
    #3;
    chk("rst_valid", valid_post_o, 1'b0);
    chk("rst_ready", ready_pre_o, 1'b1);
    chk("rst_count", count_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_afull", almost_full_o, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      valid_pre_i = vt[i].v; data_i = vt[i].d; ready_post_i = vt[i].r; flush_i = vt[i].f;
      #3;
      chk($sformatf("vec%0d_ready", i), ready_pre_o, vt[i].e_rdy);
      chk($sformatf("vec%0d_valid", i), valid_post_o, vt[i].e_vld);
      chk($sformatf("vec%0d_data", i), data_o, vt[i].e_dat);
      chk($sformatf("vec%0d_count", i), count_o, vt[i].e_cnt);
      chk($sformatf("vec%0d_afull", i), almost_full_o, vt[i].e_af);
      @(posedge clk);
      model_step(vt[i].v, vt[i].d, vt[i].r, vt[i].f);
      #1;
    end

    // Streaming through several pointer wraps
    mon_en = 1'b1;
    for (int i = 0; i < 21; i++) cyc(i < 20, 8'(i), 1'b1, 1'b0);
    mon_en = 1'b0;
    chk("stream_len", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("stream_order", got[i], i);

    // Backpressure stability with two words stored
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    stab_en = 1'b1;
    for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
    stab_en = 1'b0;

    // Flush with three words stored while both sides are active
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    cyc(1'b1, 8'hC7, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with three words stored
    cyc(1'b1, 8'hD1, 1'b0, 1'b0);
    cyc(1'b1, 8'hD2, 1'b0, 1'b0);
    cyc(1'b1, 8'hD3, 1'b0, 1'b0);
    valid_pre_i = 1'b0; ready_post_i = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid", valid_post_o, 1'b0);
    chk("arst_ready", ready_pre_o, 1'b1);
    chk("arst_count", count_o, 0);
    chk("arst_data", data_o, 0);
    chk("arst_afull", almost_full_o, 1'b0);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          $urandom_range(0, 24) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
